reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 20, cycles all domains stay in reset after a trigger.
REQ-002 SHALL have parameter NUM_DOMAINS, default 3, number of independently released reset outputs (1..8).
REQ-003 SHALL have parameter STAGE_GAP, default 16, cycles between successive domain releases (>=1).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 270000, cycles btn_n must be stably low to count as a press (10 ms at 27 MHz).
REQ-005 SHALL have parameter WDT_CYCLES, default 27000000, watchdog timeout in cycles (used only when watchdog is compiled in).
REQ-006 clk  input  1  single system clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 btn_n  input  1  external reset button, asynchronous, active-low.
REQ-009 sw_req  input  1  synchronous one-cycle software reset request.
REQ-010 wdt_kick  input  1  synchronous watchdog refresh pulse.
REQ-011 reset_o  output  NUM_DOMAINS  active-high per-domain resets; bit 0 released first.
REQ-012 busy  output  1  high while any reset_o bit is high.
REQ-013 cause  output  2  last trigger: 0 power-on, 1 button, 2 software, 3 watchdog.

Function
REQ-014 SHALL implement FSM states HOLD, RELEASE, RUN.
REQ-015 HOLD: all reset_o high, hold counter counts HOLD_CYCLES edges, then go to RELEASE with reset_o[0] cleared on that edge.
REQ-016 RELEASE: clear reset_o[k] exactly k*STAGE_GAP edges after reset_o[0]; enter RUN on the edge clearing reset_o[NUM_DOMAINS-1].
REQ-017 busy SHALL fall on the same edge as the last domain release.
REQ-018 After reset deasserts, reset_o[k] SHALL fall after rising edge 2+HOLD_CYCLES+k*STAGE_GAP (2 edges of deassert synchronisation).
REQ-019 btn_n SHALL pass a 2-flop synchroniser, then a debounce counter; trigger fires once per press when low for DEBOUNCE_CYCLES consecutive cycles; re-arms only after btn_n is seen high.
REQ-020 Any trigger in any state SHALL reassert all reset_o on the next edge, restart the hold counter and enter HOLD.
REQ-021 Simultaneous triggers priority: watchdog > button > software; cause records the winner.
REQ-022 cause SHALL update on the trigger edge and remain stable until the next trigger.
REQ-023 sw_req and wdt_kick SHALL be ignored while busy is high except that sw_req in HOLD/RELEASE is ignored (no restart).
REQ-024 NUM_DOMAINS=1: RUN entered on the edge clearing reset_o[0].

Reset
REQ-025 reset low SHALL asynchronously set all reset_o and busy high, cause=0, state HOLD, all counters zero.
REQ-026 reset deassertion SHALL be synchronised through 2 flops before the hold counter starts.
REQ-027 reset asserted mid-sequence SHALL immediately re-assert all domains regardless of state.

Configuration
REQ-028 Macro RESET_SEQ_WATCHDOG_EN defined: counter increments in RUN, clears on wdt_kick or entering RUN; reaching WDT_CYCLES fires a watchdog trigger (cause=3).
REQ-029 Macro undefined: no watchdog logic, wdt_kick ignored, cause never 3.

Structure
REQ-030 Shared package SHALL hold the state enum (HOLD/RELEASE/RUN) and cause codes (CAUSE_POR, CAUSE_BTN, CAUSE_SW, CAUSE_WDT).
REQ-031 Button synchroniser+debouncer SHALL be a sub-module btn_debouncer (params DEBOUNCE_CYCLES; outputs one-cycle press pulse).
REQ-032 Counter widths SHALL be $clog2 of their maximum count +1.

Verification (HOLD_CYCLES=20, NUM_DOMAINS=3, STAGE_GAP=4, DEBOUNCE_CYCLES=8, WDT_CYCLES=50)
REQ-033 Power-on: release reset -> reset_o[0] falls after edge 22, [1] after 26, [2] after 30, busy falls after 30, cause=0.
REQ-034 Button: in RUN, btn_n low 7 cycles then high -> no reset; low 8 cycles -> all reset_o high next edge, cause=1, release sequence repeats with same spacing.
REQ-035 Software: sw_req pulse in RUN -> reset_o=3'b111 next edge, cause=2; sw_req during RELEASE -> ignored.
REQ-036 Mid-sequence: reset low after edge 24 (reset_o=3'b110) -> reset_o=3'b111 asynchronously, cause=0; release restarts from edge count 0.
REQ-037 Watchdog (RESET_SEQ_WATCHDOG_EN): kick every 40 cycles -> no reset; stop kicking -> reset 50 cycles after last kick, cause=3; same bench without macro -> never resets.
REQ-038 Simultaneous btn press-complete and sw_req same edge -> cause=1.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states, trigger cause codes and
// a helper that sizes counters from their maximum count.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_BTN = 2'd1,
    CAUSE_SW  = 2'd2,
    CAUSE_WDT = 2'd3
  } cause_t;

  function automatic int unsigned cnt_w(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_btn.sv
// Button synchroniser and debouncer: one-cycle press pulse on the
// DEBOUNCE_CYCLES-th consecutive low sample; re-arms once btn_n is seen high.
module btn_debouncer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Counter saturates at DEBOUNCE_CYCLES so a held button fires only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      if (sync_q[1])
        cnt_q <= '0;
      else if (cnt_q != CW'(DEBOUNCE_CYCLES))
        cnt_q <= cnt_q + CW'(1);
    end
  end

  assign press = !sync_q[1] && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: hold all domains, then release them one by one.
// Optional watchdog trigger compiled in with RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 20,
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned WDT_CYCLES      = 27000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_n,
  input  logic                   sw_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] reset_o,
  output logic                   busy,
  output logic [1:0]             cause
);

  localparam int unsigned HW = cnt_w(HOLD_CYCLES);
  localparam int unsigned GW = cnt_w(STAGE_GAP);
  localparam int unsigned IW = cnt_w(NUM_DOMAINS);

  state_t                 state_q, state_d;
  cause_t                 cause_q, cause_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [1:0]             rsync_q;
  logic                   run_en, btn_press, sw_trig, wdt_trig, trig;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .press (btn_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsync_q <= '0;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end
  assign run_en = rsync_q[1];

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int unsigned WW = cnt_w(WDT_CYCLES);
  logic [WW-1:0] wdt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wdt_q <= '0;
    else if (state_q != RUN || wdt_kick || wdt_trig)
      wdt_q <= '0;
    else
      wdt_q <= wdt_q + WW'(1);
  end

  assign wdt_trig = (state_q == RUN) && !wdt_kick && (wdt_q == WW'(WDT_CYCLES - 1));
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
  assign wdt_trig   = 1'b0;
`endif

  // Software requests are honoured only once every domain is running.
  assign sw_trig = sw_req && (state_q == RUN);
  assign trig    = wdt_trig || btn_press || sw_trig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD;
      cause_q <= CAUSE_POR;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    if (trig) begin
      state_d = HOLD;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      if (wdt_trig)       cause_d = CAUSE_WDT;
      else if (btn_press) cause_d = CAUSE_BTN;
      else                cause_d = CAUSE_SW;
    end else begin
      case (state_q)
        HOLD: begin
          if (run_en) begin
            if (hold_q == HW'(HOLD_CYCLES - 1)) begin
              hold_d   = '0;
              gap_d    = '0;
              idx_d    = IW'(1);
              rst_d[0] = 1'b0;
              state_d  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        RELEASE: begin
          if (gap_q == GW'(STAGE_GAP - 1)) begin
            gap_d = '0;
            idx_d = idx_q + IW'(1);
            for (int unsigned k = 0; k < NUM_DOMAINS; k++)
              if (idx_q == IW'(k)) rst_d[k] = 1'b0;
            if (idx_q == IW'(NUM_DOMAINS - 1)) state_d = RUN;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        RUN: begin
        end
        default: state_d = HOLD;
      endcase
    end
  end

  assign reset_o = rst_q;
  assign busy    = |rst_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random stimulus, all
// checked each cycle against a sequence-age reference model.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int HOLD = 20;
  localparam int ND   = 3;
  localparam int GAP  = 4;
  localparam int DEB  = 8;
  localparam int WDT  = 50;
  localparam int LAST = HOLD + (ND - 1) * GAP;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b1;
  logic sw_req = 1'b0;
  logic wdt_kick = 1'b0;
  logic [ND-1:0] reset_o;
  logic busy;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;
  bit auto_kick = 1'b1;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .NUM_DOMAINS    (ND),
    .STAGE_GAP      (GAP),
    .DEBOUNCE_CYCLES(DEB),
    .WDT_CYCLES     (WDT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .sw_req  (sw_req),
    .wdt_kick(wdt_kick),
    .reset_o (reset_o),
    .busy    (busy),
    .cause   (cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: age = edges since the sequence (re)started; domain k is
  // out of reset once age reaches HOLD + k*GAP. Negative age = reset sync.
  int age = -2;
  int edge_no = 0;
  int last_ref = 0;
  int low_run = 0;
  bit btn_pipe[$] = '{1'b1, 1'b1};
  logic [1:0] m_cause = 2'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age      = -2;
      m_cause  = 2'd0;
      low_run  = 0;
      btn_pipe = '{1'b1, 1'b1};
    end else begin
      bit d, pressed, wdt_fire, sw_fire, running;
      edge_no++;
      btn_pipe.push_back(btn_n);
      d = btn_pipe.pop_front();
      low_run = d ? 0 : low_run + 1;
      pressed = !d && (low_run == DEB);
      running = (age >= LAST);
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_fire = running && !wdt_kick && (edge_no - last_ref == WDT);
`else
      wdt_fire = 1'b0;
`endif
      sw_fire = sw_req && running;
      if (running && wdt_kick) last_ref = edge_no;
      if (wdt_fire || pressed || sw_fire) begin
        m_cause = wdt_fire ? 2'd3 : (pressed ? 2'd1 : 2'd2);
        age = (age >= 0) ? 0 : age + 1;
      end else begin
        if (age < LAST) age++;
        if (age == LAST && !running) last_ref = edge_no;
      end
    end
  end

  function automatic logic [ND-1:0] exp_rst(input int a);
    logic [ND-1:0] r;
    for (int k = 0; k < ND; k++) r[k] = !(a >= HOLD + k * GAP);
    return r;
  endfunction

  always @(negedge clk) begin
    logic [ND-1:0] e;
    e = exp_rst(age);
    check("model_reset_o", reset_o, e);
    check("model_busy", busy, |e);
    check("model_cause", cause, m_cause);
  end

  initial begin
    forever begin
      repeat (40) @(negedge clk);
      if (auto_kick) begin
        wdt_kick = 1'b1;
        @(negedge clk);
        wdt_kick = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int n);
    btn_n = 1'b0;
    repeat (n) @(negedge clk);
    btn_n = 1'b1;
  endtask

  task automatic pulse_sw();
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
  endtask

  task automatic wait_rst(input logic [ND-1:0] val, input int max, input string tag);
    int i = 0;
    while (reset_o !== val && i < max) begin
      @(negedge clk);
      i++;
    end
    check(tag, reset_o, val);
  endtask

  initial begin
    cycles(3);
    check("rst_state_o", reset_o, 3'b111);
    check("rst_state_busy", busy, 1'b1);
    check("rst_state_cause", cause, CAUSE_POR);

    // Power-on release timing
    reset = 1'b1;
    repeat (21) @(posedge clk); #1 check("por_e21", reset_o, 3'b111);
    @(posedge clk);             #1 check("por_e22", reset_o, 3'b110);
    repeat (4) @(posedge clk);  #1 check("por_e26", reset_o, 3'b100);
    repeat (3) @(posedge clk);  #1 check("por_e29", reset_o, 3'b100);
    @(posedge clk);             #1 check("por_e30", reset_o, 3'b000);
    check("por_busy", busy, 1'b0);
    check("por_cause", cause, CAUSE_POR);

    // Button: one short of debounce, then exactly debounce length
    cycles(5);
    press_btn(7);
    cycles(15);
    check("btn_short", busy, 1'b0);
    press_btn(8);
    @(posedge clk); #1 check("btn_pre", reset_o, 3'b000);
    @(posedge clk); #1 check("btn_hit", reset_o, 3'b111);
    check("btn_cause", cause, CAUSE_BTN);
    repeat (20) @(posedge clk); #1 check("btn_rel0", reset_o, 3'b110);
    repeat (4) @(posedge clk);  #1 check("btn_rel1", reset_o, 3'b100);
    repeat (4) @(posedge clk);  #1 check("btn_rel2", reset_o, 3'b000);

    // Software request in RUN, then ignored during RELEASE
    @(negedge clk);
    pulse_sw();
    check("sw_hit", reset_o, 3'b111);
    check("sw_cause", cause, CAUSE_SW);
    wait_rst(3'b110, 40, "sw_reach_release");
    pulse_sw();
    check("sw_in_release", reset_o, 3'b110);
    check("sw_ign_cause", cause, CAUSE_SW);
    wait_rst(3'b000, 40, "sw_done");

    // Button completion and software request on the same edge
    cycles(3);
    btn_n = 1'b0;
    repeat (8) @(negedge clk);
    btn_n = 1'b1;
    @(negedge clk);
    pulse_sw();
    check("simul_rst", reset_o, 3'b111);
    check("simul_cause", cause, CAUSE_BTN);
    wait_rst(3'b000, 60, "simul_done");

    // Reset asserted mid-release
    pulse_sw();
    wait_rst(3'b110, 40, "mid_reach");
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("mid_async", reset_o, 3'b111);
    check("mid_busy", busy, 1'b1);
    check("mid_cause", cause, CAUSE_POR);
    @(negedge clk);
    reset = 1'b1;
    repeat (21) @(posedge clk); #1 check("mid_e21", reset_o, 3'b111);
    @(posedge clk);             #1 check("mid_e22", reset_o, 3'b110);
    wait_rst(3'b000, 20, "mid_done");

    // Watchdog: regular kicks keep it quiet, silence fires it if built in
    cycles(200);
    check("wdt_kicked", busy, 1'b0);
    auto_kick = 1'b0;
    cycles(60);
`ifdef RESET_SEQ_WATCHDOG_EN
    check("wdt_cause", cause, CAUSE_WDT);
`else
    check("wdt_none_busy", busy, 1'b0);
    check("wdt_none_cause", cause, CAUSE_POR);
`endif
    auto_kick = 1'b1;
    wait_rst(3'b000, 80, "wdt_settle");

    // Random mix of presses, requests, kick gating and async resets
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: press_btn(int'($urandom_range(5, 10)));
        1: pulse_sw();
        2: cycles(int'($urandom_range(1, 30)));
        3: begin
          auto_kick = ($urandom_range(0, 3) != 0);
          cycles(int'($urandom_range(1, 20)));
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            #3 reset = 1'b0;
            cycles(2);
            reset = 1'b1;
          end
        end
      endcase
    end
    auto_kick = 1'b1;
    cycles(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
